// File: rtl/fifo_write_logic.sv
// ---------------------------------------------------------------------------
// fifo_write_logic
//   Write side of a packet FIFO. Accepts a byte stream framed by in_last,
//   writes each byte into the packet buffer at (slot, byte index), then
//   publishes the slot through the index map and advances the Gray write
//   pointer that the read domain synchronizes.
//
// Optional feature macro: FIFO_WR_DROP_RUNT_EN
//   When defined, packets shorter than 2 bytes are dropped (no index-map
//   write, no pointer advance, pkt_err pulse). Default build commits them.
//
// Ports
//   clk1        write-domain clock
//   rst         synchronous active-high reset
//   in_valid    input byte valid
//   in_data     input byte
//   in_last     final byte of packet
//   in_ready    byte accepted this cycle when in_valid is also high
//   wq2_rptr    Gray read pointer, already synchronized into clk1
//   uwrite_en   packet-buffer write strobe (registered)
//   uaddr       packet-buffer slot
//   uaddr_in    byte index inside the slot
//   udata       byte written
//   iwrite_en   index-map write strobe (registered, one COMMIT cycle)
//   iaddr       index-map position
//   idata       slot number written into the index map
//   wptr_gray   registered Gray write pointer
//   full        all slots committed and unread (combinational)
//   pkt_err     one-cycle pulse: packet truncated or dropped
// ---------------------------------------------------------------------------
module fifo_write_logic #(
    parameter int DEPTH     = 4,
    parameter int UWIDTH    = 8,
    parameter int PTR_SZ    = 2,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [UWIDTH-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic [PTR_SZ:0]      wq2_rptr,
    output logic                 uwrite_en,
    output logic [PTR_SZ-1:0]    uaddr,
    output logic [PTR_IN_SZ-1:0] uaddr_in,
    output logic [UWIDTH-1:0]    udata,
    output logic                 iwrite_en,
    output logic [PTR_SZ-1:0]    iaddr,
    output logic [PTR_SZ-1:0]    idata,
    output logic [PTR_SZ:0]      wptr_gray,
    output logic                 full,
    output logic                 pkt_err
);

    // Slot count and pointer width must agree for the Gray full compare.
    if (DEPTH != (1 << PTR_SZ)) begin : g_depth_check
        $error("fifo_write_logic: DEPTH must equal 2**PTR_SZ");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Byte counter is one bit wider so it can hold the "slot full" value.
    localparam logic [PTR_IN_SZ:0] MAX_BYTES = {1'b1, {PTR_IN_SZ{1'b0}}};
    localparam logic [PTR_IN_SZ:0] CNT_ONE   = {{PTR_IN_SZ{1'b0}}, 1'b1};
    localparam logic [PTR_SZ:0]    PTR_ONE   = {{PTR_SZ{1'b0}}, 1'b1};

    state_t                 r_state;
    logic [PTR_SZ:0]        r_wptr;
    logic [PTR_SZ:0]        r_wptr_gray;
    logic [PTR_IN_SZ:0]     r_cnt;
    logic                   r_trunc;
    logic                   r_drop;
    logic                   r_uwrite_en;
    logic [PTR_SZ-1:0]      r_uaddr;
    logic [PTR_IN_SZ-1:0]   r_uaddr_in;
    logic [UWIDTH-1:0]      r_udata;
    logic                   r_iwrite_en;
    logic [PTR_SZ-1:0]      r_iaddr;
    logic [PTR_SZ-1:0]      r_idata;
    logic                   r_pkt_err;

    logic                   w_full;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_room;
    logic                   w_trunc;
    logic [PTR_SZ:0]        w_wptr_nxt;
`ifdef FIFO_WR_DROP_RUNT_EN
    logic                   w_runt;
`endif

    // Full when the write pointer has lapped the read pointer: top two Gray
    // bits inverted, the rest equal.
    assign w_full = (r_wptr_gray ==
                     {~wq2_rptr[PTR_SZ:PTR_SZ-1], wq2_rptr[PTR_SZ-2:0]});

    // RECV ignores full: the slot being filled was owned before full rose.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:   w_ready = !w_full;
            S_RECV:   w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    assign w_accept   = in_valid && w_ready;
    assign w_room     = (r_cnt != MAX_BYTES);
    assign w_trunc    = r_trunc || !w_room;
    assign w_wptr_nxt = r_wptr + PTR_ONE;
`ifdef FIFO_WR_DROP_RUNT_EN
    // A last byte seen in IDLE means the packet holds a single byte.
    assign w_runt     = (r_state == S_IDLE);
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_wptr_gray <= '0;
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
            r_drop      <= 1'b0;
            r_uwrite_en <= 1'b0;
            r_uaddr     <= '0;
            r_uaddr_in  <= '0;
            r_udata     <= '0;
            r_iwrite_en <= 1'b0;
            r_iaddr     <= '0;
            r_idata     <= '0;
            r_pkt_err   <= 1'b0;
        end else begin
            r_uwrite_en <= 1'b0;
            r_iwrite_en <= 1'b0;
            r_pkt_err   <= 1'b0;
            case (r_state)
                S_IDLE, S_RECV: begin
                    if (w_accept) begin
                        // Bytes past the slot size are swallowed, not written.
                        if (w_room) begin
                            r_uwrite_en <= 1'b1;
                            r_uaddr     <= r_wptr[PTR_SZ-1:0];
                            r_uaddr_in  <= r_cnt[PTR_IN_SZ-1:0];
                            r_udata     <= in_data;
                            r_cnt       <= r_cnt + CNT_ONE;
                        end
                        if (in_last) begin
                            r_state <= S_COMMIT;
`ifdef FIFO_WR_DROP_RUNT_EN
                            if (w_runt) begin
                                r_drop    <= 1'b1;
                                r_pkt_err <= 1'b1;
                            end else begin
                                r_iwrite_en <= 1'b1;
                                r_iaddr     <= r_wptr[PTR_SZ-1:0];
                                r_idata     <= r_wptr[PTR_SZ-1:0];
                                r_pkt_err   <= w_trunc;
                            end
`else
                            r_iwrite_en <= 1'b1;
                            r_iaddr     <= r_wptr[PTR_SZ-1:0];
                            r_idata     <= r_wptr[PTR_SZ-1:0];
                            r_pkt_err   <= w_trunc;
`endif
                        end else begin
                            r_state <= S_RECV;
                            if (!w_room) begin
                                r_trunc <= 1'b1;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_trunc <= 1'b0;
                    r_drop  <= 1'b0;
                    // Gray is loaded from the next binary value so that full
                    // in the following IDLE cycle already sees the new slot.
                    if (!r_drop) begin
                        r_wptr      <= w_wptr_nxt;
                        r_wptr_gray <= w_wptr_nxt ^ (w_wptr_nxt >> 1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign full      = w_full;
    assign uwrite_en = r_uwrite_en;
    assign uaddr     = r_uaddr;
    assign uaddr_in  = r_uaddr_in;
    assign udata     = r_udata;
    assign iwrite_en = r_iwrite_en;
    assign iaddr     = r_iaddr;
    assign idata     = r_idata;
    assign wptr_gray = r_wptr_gray;
    assign pkt_err   = r_pkt_err;

endmodule

// File: doc/fifo_write_logic.md
FIFO_WRITE_LOGIC -- requirements
Module: fifo_write_logic

Interface
REQ-001 Parameter DEPTH, 4, number of packet slots; SHALL equal 2**PTR_SZ.
REQ-002 Parameter UWIDTH, 8, byte width of packet data.
REQ-003 Parameter PTR_SZ, 2, slot index width.
REQ-004 Parameter PTR_IN_SZ, 4, byte-in-slot index width; max packet 2**PTR_IN_SZ bytes.
REQ-005 Port clk1  in  1  write-domain clock; one clock; reset is synchronous and active-high.
REQ-006 Port rst  in  1  synchronous active-high reset, sampled on clk1 rising edge.
REQ-007 Port in_valid  in  1  input byte valid.
REQ-008 Port in_data  in  UWIDTH  input byte.
REQ-009 Port in_last  in  1  marks final byte of packet.
REQ-010 Port in_ready  out  1  block accepts byte this cycle.
REQ-011 Port wq2_rptr  in  PTR_SZ+1  Gray read pointer, already synchronized into clk1.
REQ-012 Port uwrite_en/uaddr/uaddr_in/udata  out  1/PTR_SZ/PTR_IN_SZ/UWIDTH  packet-buffer byte write.
REQ-013 Port iwrite_en/iaddr/idata  out  1/PTR_SZ/PTR_SZ  index-map write: slot idata at position iaddr.
REQ-014 Port wptr_gray  out  PTR_SZ+1  registered Gray write pointer for read-domain sync.
REQ-015 Port full  out  1  all slots committed and unread.
REQ-016 Port pkt_err  out  1  one-cycle pulse: packet truncated or dropped.

Function
REQ-017 Byte accepted iff in_valid && in_ready on a clk1 edge.
REQ-018 FSM states IDLE, RECV, COMMIT; IDLE->RECV on first accepted byte without in_last; IDLE/RECV->COMMIT on accepted byte with in_last; COMMIT->IDLE after one cycle.
REQ-019 in_ready = !full in IDLE; 1 in RECV; 0 in COMMIT.
REQ-020 Accepted byte SHALL drive uwrite_en=1, uaddr=wptr[PTR_SZ-1:0], uaddr_in=byte count, udata=in_data, registered, one cycle after acceptance; uwrite_en=0 otherwise.
REQ-021 Byte count SHALL reset to 0 on entering IDLE and increment per accepted byte.
REQ-022 Bytes beyond 2**PTR_IN_SZ SHALL be accepted but not written; pkt_err pulses once at COMMIT; packet still committed (truncated).
REQ-023 COMMIT SHALL drive iwrite_en=1, iaddr=idata=wptr[PTR_SZ-1:0] for exactly one cycle.
REQ-024 Binary wptr (PTR_SZ+1 bits) SHALL increment at end of COMMIT, wrapping modulo 2**(PTR_SZ+1); wptr_gray=(wptr>>1)^wptr, registered, valid the cycle after increment.
REQ-025 full SHALL be combinational: wptr_gray == {~wq2_rptr[PTR_SZ:PTR_SZ-1], wq2_rptr[PTR_SZ-2:0]}.
REQ-026 full asserting mid-packet SHALL NOT stall RECV; the current slot is already owned.
REQ-027 Simultaneous wq2_rptr change and COMMIT: full evaluated on post-increment wptr the following cycle.
REQ-028 Byte with in_valid && in_last in IDLE while full: not accepted; no state change.

Reset
REQ-029 On rst: state IDLE, wptr=0, wptr_gray=0, byte count 0, uwrite_en=0, uaddr=0, uaddr_in=0, udata=0, iwrite_en=0, iaddr=0, idata=0, pkt_err=0.
REQ-030 rst mid-packet SHALL abandon the packet without index-map write; in_ready=1 first cycle after reset if !full.

Configuration
REQ-031 Macro FIFO_WR_DROP_RUNT_EN defined: packets of fewer than 2 bytes (no DEST_ID byte 1) SHALL skip index-map write, not advance wptr, pulse pkt_err; COMMIT cycle still spent.
REQ-032 Macro undefined: runt packets SHALL be committed like any other; pkt_err only on truncation.

Verification
REQ-033 5-byte packet 0x05,0x80,0xAA,0xBB,0xCC into empty FIFO -> uaddr=0, uaddr_in 0..4, then iwrite_en iaddr=0 idata=0, wptr_gray=3'b001.
REQ-034 4 packets with wq2_rptr=0 -> full=1, wptr_gray=3'b110, in_ready=0 in IDLE; wq2_rptr=3'b001 -> full=0.
REQ-035 20-byte packet -> only uaddr_in 0..15 written, pkt_err pulse at COMMIT, wptr advances by 1.
REQ-036 1-byte packet: with FIFO_WR_DROP_RUNT_EN -> no iwrite_en, wptr unchanged, pkt_err=1; without -> committed, pkt_err=0.
REQ-037 rst after 3 bytes of a packet -> no iwrite_en, all outputs 0, next packet written from uaddr_in=0 into slot 0.
REQ-038 8 back-to-back packets with reader tracking -> wptr wraps 3'b111->3'b000, slots cycle 0..3 twice, full never asserted.
